// File: rtl/result_checker_pkg.sv
// Shared definitions for the result checker: operation encodings,
// FSM state type and counter width.
package result_checker_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/result_checker_ref.sv
// Combinational reference model: expected 2-bit result of a op b.
module result_checker_ref
  import result_checker_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op_sel,
  output logic [1:0] exp_c
);

  // Select the reference operation; ADD wraps naturally in 2 bits
  always_comb begin
    exp_c = '0;
    case (op_e'(op_sel))
      OP_AND:  exp_c = a & b;
      OP_OR:   exp_c = a | b;
      OP_XOR:  exp_c = a ^ b;
      OP_ADD:  exp_c = a + b;
      default: exp_c = '0;
    endcase
  end

endmodule

// File: rtl/result_checker.sv
// Result checker: runs num_vec vectors, compares DUT result c against the
// reference operation and accumulates pass/fail statistics.
module result_checker
  import result_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [1:0]       op_sel,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic [1:0]       c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       exp_c;

  result_checker_ref u_ref (
    .a      (a),
    .b      (b),
    .op_sel (op_q),
    .exp_c  (exp_c)
  );

  // Next-state, index and result-register update
  always_comb begin
    state_d = state_q;
    nv_d    = nv_q;
    op_d    = op_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nv_d    = num_vec;
          op_d    = op_e'(op_sel);
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (vec_valid) begin
          if (c == exp_c) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
            if (!ffv_q) begin
              ffi_d = idx_q;
              ffv_d = 1'b1;
            end
          end
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == nv_q - CNT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nv_q    <= '0;
      op_q    <= OP_AND;
      idx_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nv_q    <= nv_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
    end
  end

  assign vec_ready      = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: directed table, multi-cycle
// corner sequences and randomized runs against a behavioural model.
module tb_result_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_vec = '0;
  logic [1:0] op_sel = '0;
  logic       vec_valid = 1'b0;
  logic       vec_ready;
  logic [1:0] a = '0, b = '0, c = '0;
  logic       busy, done;
  logic [7:0] pass_cnt, fail_cnt, first_fail_idx;
  logic       first_fail_vld;

  int errors = 0;
  int checks = 0;

  // behavioural model of the current run
  int m_op, m_pass, m_fail, m_ffi, m_ffv, m_idx;

  always #5 clk = ~clk;

  result_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vec        (num_vec),
    .op_sel         (op_sel),
    .vec_valid      (vec_valid),
    .vec_ready      (vec_ready),
    .a              (a),
    .b              (b),
    .c              (c),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
  );

  function automatic int ref_op(int op, int x, int y);
    case (op)
      0:       return x & y;
      1:       return x | y;
      2:       return x ^ y;
      default: return (x + y) % 4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
    chk({nm, " fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    chk({nm, " ffv"}, 32'(first_fail_vld), 32'(m_ffv));
    chk({nm, " ffi"}, 32'(first_fail_idx), 32'(m_ffi));
  endtask

  // caller is at a negedge; start is sampled on the next rising edge
  task automatic do_start(input int nv, input int op);
    start = 1'b1; num_vec = 8'(nv); op_sel = 2'(op);
    @(negedge clk);
    start = 1'b0;
    m_op = op; m_pass = 0; m_fail = 0; m_ffi = 0; m_ffv = 0; m_idx = 0;
    if (nv == 0) begin
      chk("zero done", 32'(done), 1);
      chk("zero busy", 32'(busy), 0);
    end else begin
      chk("start busy", 32'(busy), 1);
      chk("start ready", 32'(vec_ready), 1);
    end
    chk_model("start");
  endtask

  // stall cycles first (valid low, junk data, optional ignored start), then one vector
  task automatic send_vec(input int va, input int vb, input int vc, input int stall, input bit poke_start);
    int exp;
    int wait_cnt;
    for (int s = 0; s < stall; s++) begin
      vec_valid = 1'b0;
      a = 2'($urandom); b = 2'($urandom); c = 2'($urandom);
      start = poke_start; num_vec = 8'd1; op_sel = 2'($urandom);
      @(negedge clk);
      start = 1'b0;
      chk("stall busy", 32'(busy), 1);
      chk_model("stall");
    end
    a = 2'(va); b = 2'(vb); c = 2'(vc); vec_valid = 1'b1;
    wait_cnt = 0;
    while (!vec_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!vec_ready) begin
      chk("vec_ready timeout", 0, 1);
      vec_valid = 1'b0;
      return;
    end
    @(negedge clk);
    vec_valid = 1'b0;
    exp = ref_op(m_op, va, vb);
    if (vc == exp) begin
      if (m_pass < 255) m_pass++;
    end else begin
      if (m_fail < 255) m_fail++;
      if (m_ffv == 0) begin m_ffv = 1; m_ffi = m_idx; end
    end
    m_idx++;
    chk_model("vec");
  endtask

  typedef struct {
    int op; int va; int vb; int vc; int exp_pass; int exp_fail;
  } tv_t;

  tv_t tab[8];

  initial begin
    tab[0] = '{0, 3, 2, 2, 1, 0};  // AND pass
    tab[1] = '{0, 1, 2, 1, 0, 1};  // AND fail (exp 0)
    tab[2] = '{1, 1, 2, 3, 1, 0};  // OR pass
    tab[3] = '{1, 1, 2, 1, 0, 1};  // OR fail
    tab[4] = '{2, 3, 1, 2, 1, 0};  // XOR pass
    tab[5] = '{2, 3, 3, 3, 0, 1};  // XOR fail (exp 0)
    tab[6] = '{3, 3, 3, 2, 1, 0};  // ADD 6 mod 4 = 2
    tab[7] = '{3, 2, 3, 0, 0, 1};  // ADD fail (exp 1)

    // reset state
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst ready", 32'(vec_ready), 0);
    chk("rst pass", 32'(pass_cnt), 0);
    chk("rst fail", 32'(fail_cnt), 0);
    chk("rst ffi", 32'(first_fail_idx), 0);
    chk("rst ffv", 32'(first_fail_vld), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed single-vector table
    foreach (tab[i]) begin
      do_start(1, tab[i].op);
      send_vec(tab[i].va, tab[i].vb, tab[i].vc, 0, 1'b0);
      chk("tab pass", 32'(pass_cnt), 32'(tab[i].exp_pass));
      chk("tab fail", 32'(fail_cnt), 32'(tab[i].exp_fail));
      chk("tab ffv", 32'(first_fail_vld), 32'(tab[i].exp_fail));
      chk("tab done", 32'(done), 1);
    end

    // mixed ADD run
    do_start(3, 3);
    send_vec(3, 2, 1, 0, 1'b0);
    send_vec(1, 1, 3, 0, 1'b0);
    send_vec(2, 2, 1, 0, 1'b0);
    chk("mixed pass", 32'(pass_cnt), 1);
    chk("mixed fail", 32'(fail_cnt), 2);
    chk("mixed ffi", 32'(first_fail_idx), 1);
    chk("mixed done", 32'(done), 1);

    // valid while DONE has no effect, results hold
    vec_valid = 1'b1; a = 2'd0; b = 2'd0; c = 2'd3;
    repeat (3) @(negedge clk);
    vec_valid = 1'b0;
    chk("done ready", 32'(vec_ready), 0);
    chk("done hold pass", 32'(pass_cnt), 1);
    chk("done hold fail", 32'(fail_cnt), 2);
    chk("done hold ffi", 32'(first_fail_idx), 1);

    // stall with ignored start mid-run
    do_start(2, 2);
    send_vec(1, 2, 3, 0, 1'b0);
    send_vec(3, 3, 1, 5, 1'b1);
    chk("stall done", 32'(done), 1);
    chk("stall pass", 32'(pass_cnt), 1);
    chk("stall fail", 32'(fail_cnt), 1);
    chk("stall ffi", 32'(first_fail_idx), 1);

    // zero-length run
    do_start(0, 1);
    chk("zero pass", 32'(pass_cnt), 0);

    // 255 passing vectors
    do_start(255, 3);
    for (int i = 0; i < 255; i++) begin
      int x, y;
      x = $urandom_range(0, 3); y = $urandom_range(0, 3);
      send_vec(x, y, ref_op(3, x, y), 0, 1'b0);
    end
    chk("sat pass", 32'(pass_cnt), 255);
    chk("sat done", 32'(done), 1);
    chk("sat fail", 32'(fail_cnt), 0);

    // reset mid-run
    do_start(4, 0);
    send_vec(3, 3, 3, 0, 1'b0);
    send_vec(1, 1, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst ready", 32'(vec_ready), 0);
    chk("midrst pass", 32'(pass_cnt), 0);
    chk("midrst fail", 32'(fail_cnt), 0);
    chk("midrst ffv", 32'(first_fail_vld), 0);
    chk("midrst ffi", 32'(first_fail_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1, 1);
    send_vec(2, 1, 3, 0, 1'b0);
    chk("post rst done", 32'(done), 1);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int nv, op;
      nv = $urandom_range(1, 12);
      op = $urandom_range(0, 3);
      do_start(nv, op);
      for (int i = 0; i < nv; i++) begin
        int x, y, z;
        x = $urandom_range(0, 3); y = $urandom_range(0, 3);
        z = ($urandom_range(0, 1) == 1) ? ref_op(op, x, y) : $urandom_range(0, 3);
        send_vec(x, y, z, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      chk("rand done", 32'(done), 1);
      chk("rand busy", 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 The block SHALL have this port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-002 The block SHALL have this port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have this port: start  input  1  one-cycle pulse that begins a check run.
REQ-004 The block SHALL have this port: num_vec  input  8  number of vectors in the run, sampled on accepted start.
REQ-005 The block SHALL have this port: op_sel  input  2  reference operation (00 AND, 01 OR, 10 XOR, 11 ADD mod 4), sampled on accepted start.
REQ-006 The block SHALL have this port: vec_valid  input  1  upstream presents a vector.
REQ-007 The block SHALL have this port: vec_ready  output  1  checker accepts a vector this cycle.
REQ-008 The block SHALL have these ports: a, b, c  input  2 each  operands A and B and the DUT result C for the same vector.
REQ-009 The block SHALL have this port: busy  output  1  high while in RUN.
REQ-010 The block SHALL have this port: done  output  1  high while in DONE.
REQ-011 The block SHALL have these ports: pass_cnt, fail_cnt  output  8 each  matching and mismatching vector counts.
REQ-012 The block SHALL have these ports: first_fail_idx  output  8  and first_fail_vld  output  1, giving the index of the first mismatch.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-014 In IDLE or DONE, start=1 SHALL clear all counters, first_fail_vld and the vector index, latch num_vec and op_sel, and go to RUN; if num_vec=0, it SHALL go directly to DONE instead.
REQ-015 start SHALL be ignored while in RUN.
REQ-016 vec_ready SHALL be 1 exactly when the state is RUN; a vector is accepted on a cycle where vec_valid and vec_ready are both 1.
REQ-017 On each accepted vector the block SHALL compute the expected value from a, b and the latched op_sel (ADD = (a+b) mod 4, width 2) and compare it with c.
REQ-018 If c equals the expected value, pass_cnt SHALL increment; otherwise fail_cnt SHALL increment. Counters SHALL update on the edge that accepts the vector, giving one cycle of latency to the outputs.
REQ-019 On the first mismatch of a run, the block SHALL set first_fail_idx to the zero-based vector index and set first_fail_vld=1; later mismatches SHALL NOT change either output.
REQ-020 pass_cnt and fail_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-021 When the vector accepted is index num_vec-1, the FSM SHALL go to DONE on that same edge; for num_vec=255 it SHALL accept exactly 255 vectors.
REQ-022 In DONE, vec_ready SHALL be 0; all results SHALL hold until the next accepted start.
REQ-023 vec_valid without ready SHALL have no effect; a stalled upstream (vec_valid=0) SHALL NOT advance the index.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL drive state=IDLE, vec_ready=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail_idx=0 and first_fail_vld=0.
REQ-025 A reset asserted during RUN SHALL abort the run with no partial results retained.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the op_sel encodings (OP_AND, OP_OR, OP_XOR, OP_ADD), the FSM state type and the 8-bit count width constant.
REQ-028 The expected-value computation SHALL be a combinational sub-module named result_checker_ref, with inputs a, b and op_sel and a 2-bit output.
REQ-029 The top module SHALL contain only the FSM, the index counter and the result registers.

Verification
REQ-030 Single pass: op_sel=AND, num_vec=1, a=3, b=2, c=2 -> pass_cnt=1, fail_cnt=0, done=1, first_fail_vld=0.
REQ-031 Mixed run: op_sel=ADD, num_vec=3, vectors (3,2,c=1), (1,1,c=3), (2,2,c=1) -> pass_cnt=1, fail_cnt=2, first_fail_idx=1.
REQ-032 Stall and ignored start: op_sel=XOR, num_vec=2, vec_valid low for 5 cycles between vectors, start pulsed mid-run -> exactly 2 vectors accepted, no restart, done after the second vector.
REQ-033 Zero and saturation: num_vec=0 -> DONE one cycle after start with all counts 0; num_vec=255 with all-pass vectors -> pass_cnt=255 and no wrap.
REQ-034 Reset mid-run: rst_n=0 after 2 of 4 vectors -> all outputs 0 immediately; a new start with num_vec=1 completes normally.
